// File: rtl/fir_ctrl_pkg.sv
// Shared types and elaboration helpers for the FIR MAC sequencer.
package fir_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE,
    MAC,
    DONE
  } state_t;

  function automatic int acc_width(input int dw, input int cw, input int ntaps);
    return dw + cw + $clog2(ntaps);
  endfunction

  // Two taps are consumed per MAC cycle, so the tap count must pair up.
  function automatic bit taps_legal(input int ntaps);
    return (ntaps >= 2) && (ntaps % 2 == 0);
  endfunction

  localparam int  DEF_NTAPS    = 4;
  localparam bit  DEF_TAPS_OK  = taps_legal(DEF_NTAPS);

endpackage

// File: rtl/fir_mac2.sv
// Two unsigned multipliers feeding a three-input adder; purely combinational.
module fir_mac2
  import fir_ctrl_pkg::*;
#(
  parameter int DW = 8,
  parameter int CW = 8,
  parameter int AW = acc_width(DW, CW, DEF_NTAPS)
) (
  input  logic [AW-1:0] acc_in,
  input  logic [DW-1:0] x0,
  input  logic [DW-1:0] x1,
  input  logic [CW-1:0] c0,
  input  logic [CW-1:0] c1,
  output logic [AW-1:0] acc_out
);

  localparam int PW = DW + CW;

  logic [PW-1:0] p0;
  logic [PW-1:0] p1;

  assign p0 = {{CW{1'b0}}, x0} * {{DW{1'b0}}, c0};
  assign p1 = {{CW{1'b0}}, x1} * {{DW{1'b0}}, c1};

  assign acc_out = acc_in + AW'(p0) + AW'(p1);

endmodule

// File: rtl/fir_mac_sequencer.sv
// Unsigned NTAPS FIR: two shared multipliers over NTAPS/2 cycles, result NTAPS/2 edges after accept.
// No overlap: in_ready drops until the result is taken; coefficient writes while busy are dropped and flagged.
module fir_mac_sequencer
  import fir_ctrl_pkg::*;
#(
  parameter int DW    = 8,
  parameter int CW    = 8,
  parameter int NTAPS = 4,
  parameter int AW    = acc_width(DW, CW, NTAPS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DW-1:0]            in_data,
  input  logic                     coef_we,
  input  logic [$clog2(NTAPS)-1:0] coef_addr,
  input  logic [CW-1:0]            coef_data,
  output logic                     coef_err,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [AW-1:0]            out_data,
  output logic                     busy
);

  localparam bit TAPS_OK = taps_legal(NTAPS);
  localparam int HALF    = NTAPS / 2;
  localparam int IW      = (HALF > 1) ? $clog2(HALF) : 1;
  localparam int ADW     = $clog2(NTAPS);
  localparam logic [IW-1:0] LAST_IDX = IW'(HALF - 1);

  generate
    if (!TAPS_OK) begin : g_bad_ntaps
      $error("fir_mac_sequencer: NTAPS must be even and >= 2");
    end
  endgenerate

  state_t        state;
  logic [IW-1:0] idx;
  logic [DW-1:0] x [NTAPS];
  logic [CW-1:0] c [NTAPS];
  logic [AW-1:0] acc;
  logic [AW-1:0] mac_sum;
  logic [DW-1:0] op_x0;
  logic [DW-1:0] op_x1;
  logic [CW-1:0] op_c0;
  logic [CW-1:0] op_c1;

  // Tap pair 2*idx / 2*idx+1 selected from the registered delay line and bank.
  always_comb begin
    op_x0 = x[0];
    op_x1 = x[1];
    op_c0 = c[0];
    op_c1 = c[1];
    for (int k = 0; k < HALF; k++) begin
      if (idx == IW'(k)) begin
        op_x0 = x[2*k];
        op_x1 = x[2*k+1];
        op_c0 = c[2*k];
        op_c1 = c[2*k+1];
      end
    end
  end

  fir_mac2 #(
    .DW (DW),
    .CW (CW),
    .AW (AW)
  ) u_mac2 (
    .acc_in  (acc),
    .x0      (op_x0),
    .x1      (op_x1),
    .c0      (op_c0),
    .c1      (op_c1),
    .acc_out (mac_sum)
  );

  assign in_ready = (state == IDLE);
  assign busy     = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      acc       <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      coef_err  <= 1'b0;
      for (int k = 0; k < NTAPS; k++) begin
        x[k] <= '0;
        c[k] <= '0;
      end
    end else begin
      coef_err <= coef_we && (state != IDLE);
      case (state)
        IDLE: begin
          for (int k = 0; k < NTAPS; k++) begin
            if (coef_we && coef_addr == ADW'(k)) c[k] <= coef_data;
          end
          if (in_valid) begin
            x[0] <= in_data;
            for (int k = 1; k < NTAPS; k++) x[k] <= x[k-1];
            acc   <= '0;
            idx   <= '0;
            state <= MAC;
          end
        end
        MAC: begin
          acc <= mac_sum;
          idx <= idx + 1'b1;
          if (idx == LAST_IDX) begin
            out_data  <= mac_sum;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Directed stimulus with a queue scoreboard; a negedge monitor checks results and output latency.
module tb_fir_mac_sequencer;

  localparam int DW    = 8;
  localparam int CW    = 8;
  localparam int NTAPS = 4;
  localparam int AW    = 18;
  localparam int LAT   = NTAPS / 2;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          coef_we;
  logic [1:0]    coef_addr;
  logic [CW-1:0] coef_data;
  logic          coef_err;
  logic          out_valid;
  logic          out_ready;
  logic [AW-1:0] out_data;
  logic          busy;

  fir_mac_sequencer #(
    .DW    (DW),
    .CW    (CW),
    .NTAPS (NTAPS),
    .AW    (AW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .coef_we   (coef_we),
    .coef_addr (coef_addr),
    .coef_data (coef_data),
    .coef_err  (coef_err),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;
  logic [AW-1:0] exp_q [$];
  int            rise_q [$];
  logic          prev_valid = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: latency on each rising out_valid, data on each handshake.
  always @(negedge clk) begin
    if (out_valid && !prev_valid) begin
      if (rise_q.size() == 0) chk("spurious_out_valid", {31'b0, out_valid}, 32'd0);
      else                    chk("latency_cycle", cyc, rise_q.pop_front());
    end
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) chk("spurious_handshake", {31'b0, out_valid}, 32'd0);
      else                   chk("out_data", {14'b0, out_data}, {14'b0, exp_q.pop_front()});
    end
    prev_valid <= out_valid;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wait_idle();
    int guard = 0;
    while (!in_ready && guard < 100) begin
      @(posedge clk); #2;
      guard++;
    end
    if (!in_ready) chk("in_ready_timeout", {31'b0, in_ready}, 32'd1);
  endtask

  task automatic send(input logic [DW-1:0] d, input logic [AW-1:0] e, input bit track);
    wait_idle();
    in_valid = 1'b1;
    in_data  = d;
    if (track) begin
      exp_q.push_back(e);
      rise_q.push_back(cyc + LAT + 1);
    end
    @(posedge clk); #2;
    in_valid = 1'b0;
  endtask

  task automatic write_coef(input logic [1:0] a, input logic [CW-1:0] d);
    wait_idle();
    coef_we   = 1'b1;
    coef_addr = a;
    coef_data = d;
    @(posedge clk); #2;
    coef_we = 1'b0;
    chk("coef_err_idle", {31'b0, coef_err}, 32'd0);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(posedge clk); #2;
    rst = 1'b0;
  endtask

  initial begin
    int guard;
    rst = 1'b1; in_valid = 1'b0; in_data = '0;
    coef_we = 1'b0; coef_addr = '0; coef_data = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;

    chk("rst_in_ready",  {31'b0, in_ready},  32'd1);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_out_data",  {14'b0, out_data},  32'd0);
    chk("rst_coef_err",  {31'b0, coef_err},  32'd0);
    chk("rst_busy",      {31'b0, busy},      32'd0);

    // c = {1,2,3,4}
    for (int i = 0; i < 4; i++) write_coef(2'(i), 8'(i + 1));
    send(8'd10, 18'd10,  1'b1);
    send(8'd20, 18'd40,  1'b1);
    send(8'd30, 18'd100, 1'b1);
    send(8'd40, 18'd200, 1'b1);

    // All coefficients 255; history {40,30,20,10} shifts out.
    for (int i = 0; i < 4; i++) write_coef(2'(i), 8'd255);
    send(8'd255, 18'd87975,  1'b1);
    send(8'd255, 18'd147900, 1'b1);
    send(8'd255, 18'd205275, 1'b1);
    send(8'd255, 18'd260100, 1'b1);

    // Backpressure in DONE; offered sample 99 must be ignored.
    wait_idle();
    out_ready = 1'b0;
    send(8'd0, 18'd195075, 1'b1);
    guard = 0;
    while (!out_valid && guard < 20) begin
      @(posedge clk); #2;
      guard++;
    end
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data  = 8'd99;
      chk("hold_out_valid", {31'b0, out_valid}, 32'd1);
      chk("hold_out_data",  {14'b0, out_data},  32'd195075);
      chk("hold_in_ready",  {31'b0, in_ready},  32'd0);
      @(posedge clk); #2;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #2;
    chk("release_in_ready",  {31'b0, in_ready},  32'd1);
    chk("release_out_valid", {31'b0, out_valid}, 32'd0);
    chk("release_out_data",  {14'b0, out_data},  32'd195075);

    // Coefficient write during MAC is dropped and flagged.
    send(8'd1, 18'd130305, 1'b1);
    coef_we = 1'b1; coef_addr = 2'd0; coef_data = 8'd9;
    @(posedge clk); #2;
    coef_we = 1'b0;
    chk("coef_err_pulse", {31'b0, coef_err}, 32'd1);
    @(posedge clk); #2;
    chk("coef_err_clear", {31'b0, coef_err}, 32'd0);
    send(8'd2, 18'd65790, 1'b1);

    // Reset mid-MAC discards the pending result and clears the banks.
    send(8'd10, 18'd0, 1'b0);
    pulse_reset();
    chk("abort_in_ready",  {31'b0, in_ready},  32'd1);
    chk("abort_out_valid", {31'b0, out_valid}, 32'd0);
    chk("abort_busy",      {31'b0, busy},      32'd0);
    chk("abort_out_data",  {14'b0, out_data},  32'd0);
    send(8'd10, 18'd0, 1'b1);

    // Simultaneous coefficient write and sample accept from an empty history.
    wait_idle();
    pulse_reset();
    coef_we = 1'b1; coef_addr = 2'd0; coef_data = 8'd5;
    send(8'd7, 18'd35, 1'b1);
    coef_we = 1'b0;
    chk("simul_coef_err", {31'b0, coef_err}, 32'd0);

    guard = 0;
    while ((exp_q.size() != 0 || rise_q.size() != 0) && guard < 50) begin
      @(posedge clk); #2;
      guard++;
    end
    chk("data_queue_drained",    exp_q.size(),  32'd0);
    chk("latency_queue_drained", rise_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
